// File: rtl/mmio_pwm_responder.sv
// Memory-mapped PWM / timer responder for a small RISC-V style data bus.
// A 16-byte window at BASE_ADDR holds a 4-channel PWM duty register and
// free-running millisecond / microsecond counters, plus a read-only ID word.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   reset          synchronous active-low reset
//   funct3         load/store size and sign (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   dmem_wren      store strobe for the current address
//   dmem_address   byte address from the core
//   dmem_data_in   right-aligned store data
//   dmem_data_out  registered load data, one cycle after the address
//   led/red/green/blue  active-high PWM outputs
module mmio_pwm_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0,
  parameter int unsigned CLK_HZ    = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned US_DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
  localparam int unsigned MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [31:0] ID_VALUE = 32'h5057_4D31;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]     pwm_q;
  logic [31:0]     pwm_d;
  logic [31:0]     millis;
  logic [31:0]     micros;
  logic [7:0]      pwm_cnt;
  logic [US_W-1:0] us_presc;
  logic [MS_W-1:0] ms_presc;

  logic        hit_c;
  logic        us_tick_c;
  logic        ms_tick_c;
  logic [31:0] rd_word_c;
  logic [31:0] rd_shift_c;
  logic [31:0] load_data_c;

  assign hit_c     = (dmem_address[31:4] == BASE_ADDR[31:4]);
  assign us_tick_c = (us_presc == US_W'(US_DIV - 1));
  assign ms_tick_c = (ms_presc == MS_W'(MS_DIV - 1));

  // Read path: select word, align addressed byte/half to bit 0, extend.
  always_comb begin
    rd_word_c   = 32'h0;
    load_data_c = 32'h0;
    case (dmem_address[3:2])
      2'd0: rd_word_c = pwm_q;
      2'd1: rd_word_c = millis;
      2'd2: rd_word_c = micros;
      2'd3: rd_word_c = ID_VALUE;
      default: rd_word_c = 32'h0;
    endcase
    rd_shift_c = rd_word_c >> {dmem_address[1:0], 3'b000};
    if (hit_c) begin
      case (funct3)
        F3_B:    load_data_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
        F3_H:    load_data_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
        F3_W:    load_data_c = rd_shift_c;
        F3_BU:   load_data_c = {24'h0, rd_shift_c[7:0]};
        F3_HU:   load_data_c = {16'h0, rd_shift_c[15:0]};
        default: load_data_c = 32'h0;
      endcase
    end
  end

  // Write path: only the PWM word is writable; misaligned sh/sw are dropped.
  always_comb begin
    pwm_d = pwm_q;
    if (hit_c && dmem_wren && (dmem_address[3:2] == 2'd0)) begin
      case (funct3)
        F3_B: pwm_d[{dmem_address[1:0], 3'b000} +: 8] = dmem_data_in[7:0];
        F3_H: begin
          if (!dmem_address[0])
            pwm_d[{dmem_address[1], 4'b0000} +: 16] = dmem_data_in[15:0];
        end
        F3_W: begin
          if (dmem_address[1:0] == 2'b00)
            pwm_d = dmem_data_in;
        end
        default: pwm_d = pwm_q;
      endcase
    end
  end

  // Bus-side registers: PWM duty word and load data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_q         <= 32'h0;
      dmem_data_out <= 32'h0;
    end else begin
      pwm_q         <= pwm_d;
      dmem_data_out <= load_data_c;
    end
  end

  // Prescalers and PWM sweep counter run every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      us_presc <= '0;
      ms_presc <= '0;
      pwm_cnt  <= 8'd0;
    end else begin
      us_presc <= us_tick_c ? '0 : us_presc + US_W'(1);
      ms_presc <= ms_tick_c ? '0 : ms_presc + MS_W'(1);
      pwm_cnt  <= pwm_cnt + 8'd1;
    end
  end

  // Microsecond counter; written only on its tick, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset)
      micros <= 32'h0;
    else if (us_tick_c)
      micros <= micros + 32'd1;
  end

  // Millisecond counter; written only on its tick, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset)
      millis <= 32'h0;
    else if (ms_tick_c)
      millis <= millis + 32'd1;
  end

  // PWM outputs: high while the sweep counter is below the duty value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led   <= 1'b0;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      led   <= (pwm_cnt < pwm_q[31:24]);
      red   <= (pwm_cnt < pwm_q[23:16]);
      green <= (pwm_cnt < pwm_q[15:8]);
      blue  <= (pwm_cnt < pwm_q[7:0]);
    end
  end

endmodule

// File: tb/tb_mmio_pwm_responder.sv
// Directed bench for mmio_pwm_responder: bus decode, byte/half/word access,
// PWM duty counts, timers and reset behaviour.
module tb_mmio_pwm_responder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  funct3 = LW;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = 32'h0;
  logic [31:0] dmem_data_in = 32'h0;
  logic [31:0] dmem_data_out;
  logic        led, red, green, blue;

  int checks = 0;
  int failures = 0;

  mmio_pwm_responder #(.BASE_ADDR(BASE), .CLK_HZ(12000000)) dut (
    .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
    .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
    .dmem_data_out(dmem_data_out), .led(led), .red(red), .green(green),
    .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance from one negedge to the next.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    funct3 = f3; dmem_address = addr; dmem_data_in = data; dmem_wren = 1'b1;
    cyc();
    dmem_wren = 1'b0; dmem_data_in = 32'h0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, output logic [31:0] data);
    funct3 = f3; dmem_address = addr; dmem_wren = 1'b0;
    cyc();
    data = dmem_data_out;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int n_led, n_red, n_green, n_blue;

    // Reset state
    reset = 1'b0;
    cyc();
    cyc();
    check("rst_data_out", dmem_data_out, 32'h0);
    check("rst_outputs", {28'h0, led, red, green, blue}, 32'h0);
    reset = 1'b1;

    // Timers: 12 MHz -> 12 cycles/us, 12000 cycles/ms
    repeat (23999) cyc();
    load(LW, BASE + 32'h4, rd); check("millis_pre_inc", rd, 32'd1);
    load(LW, BASE + 32'h4, rd); check("millis_24000", rd, 32'd2);
    load(LW, BASE + 32'h8, rd); check("micros_24001", rd, 32'd2000);

    // MICROS wrap: force all-ones just after reset, tick lands on edge 12
    do_reset();
    force dut.micros = 32'hFFFF_FFFF;
    cyc();
    release dut.micros;
    load(LW, BASE + 32'h8, rd); check("micros_forced", rd, 32'hFFFF_FFFF);
    repeat (9) cyc();
    load(LW, BASE + 32'h8, rd); check("micros_wrap_pre", rd, 32'hFFFF_FFFF);
    load(LW, BASE + 32'h8, rd); check("micros_wrap", rd, 32'h0);

    // Word store/load and PWM duty counts
    store(LW, BASE, 32'hFF80_4000);
    load(LW, BASE, rd); check("pwm_lw", rd, 32'hFF80_4000);
    n_led = 0; n_red = 0; n_green = 0; n_blue = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      n_led += int'(led); n_red += int'(red);
      n_green += int'(green); n_blue += int'(blue);
    end
    check("led_high", 32'(n_led), 32'd255);
    check("red_high", 32'(n_red), 32'd128);
    check("green_high", 32'(n_green), 32'd64);
    check("blue_high", 32'(n_blue), 32'd0);

    // Read during write returns the old value
    store(LW, BASE, 32'h1122_3344);
    check("rdw_old", dmem_data_out, 32'hFF80_4000);
    load(LW, BASE, rd); check("rdw_new", rd, 32'h1122_3344);

    // Byte and half lanes with extension
    store(LB, BASE + 32'h3, 32'hFFFF_FF55);
    load(LW, BASE, rd); check("sb_lane3", rd, 32'h5522_3344);
    store(LH, BASE + 32'h2, 32'h0000_BEEF);
    load(LW, BASE, rd); check("sh_upper", rd, 32'hBEEF_3344);
    load(LH, BASE + 32'h2, rd); check("lh_neg", rd, 32'hFFFF_BEEF);
    load(LHU, BASE + 32'h2, rd); check("lhu", rd, 32'h0000_BEEF);
    load(LH, BASE, rd); check("lh_pos", rd, 32'h0000_3344);
    load(LB, BASE + 32'h1, rd); check("lb_pos", rd, 32'h0000_0033);

    // Misaligned, illegal funct3 and miss stores are dropped
    store(LW, BASE + 32'h1, 32'h0);
    store(LH, BASE + 32'h3, 32'h0);
    store(3'b011, BASE, 32'h0);
    store(LW, BASE - 32'h10, 32'h0);
    load(LW, BASE, rd); check("ignored_stores", rd, 32'hBEEF_3344);
    load(3'b011, BASE, rd); check("f3_011", rd, 32'h0);
    load(3'b110, BASE, rd); check("f3_110", rd, 32'h0);
    load(LW, BASE - 32'h10, rd); check("load_miss", rd, 32'h0);

    // Byte store from reset, lb/lbu
    do_reset();
    store(LB, BASE + 32'h2, 32'h0000_00AA);
    load(LB, BASE + 32'h2, rd); check("lb_aa", rd, 32'hFFFF_FFAA);
    load(LBU, BASE + 32'h2, rd); check("lbu_aa", rd, 32'h0000_00AA);
    load(LW, BASE, rd); check("pwm_aa", rd, 32'h00AA_0000);

    // Misaligned sh, store to RO words, ID and out-of-window
    store(LH, BASE + 32'h1, 32'h0000_1234);
    store(LW, BASE + 32'h4, 32'hDEAD_BEEF);
    store(LW, BASE + 32'hC, 32'hDEAD_BEEF);
    load(LW, BASE, rd); check("sh_misaligned", rd, 32'h00AA_0000);
    load(LW, BASE + 32'h4, rd); check("millis_ro", rd, 32'h0);
    load(LW, BASE + 32'hC, rd); check("id", rd, 32'h5057_4D31);
    load(LB, BASE + 32'hE, rd); check("id_lb2", rd, 32'h0000_0057);
    load(LW, BASE + 32'h10, rd); check("above_window", rd, 32'h0);

    // Reset wins over a simultaneous store; first store after release lands
    store(LW, BASE, 32'hFF80_4000);
    repeat (4) cyc();
    funct3 = LW; dmem_address = BASE; dmem_data_in = 32'h1234_5678; dmem_wren = 1'b1;
    reset = 1'b0;
    cyc();
    reset = 1'b1; dmem_wren = 1'b0;
    check("rst_load_in_flight", dmem_data_out, 32'h0);
    check("rst_outputs_low", {28'h0, led, red, green, blue}, 32'h0);
    store(LB, BASE, 32'h0000_0077);
    check("post_rst_read_old", dmem_data_out, 32'h0);
    load(LW, BASE, rd); check("post_rst_store", rd, 32'h0000_0077);
    load(LW, BASE + 32'h4, rd); check("millis_restart", rd, 32'h0);
    load(LW, BASE + 32'h8, rd); check("micros_restart", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
